// File: rtl/alu_muldiv_seq.sv
// Iterative MUL / DIVU / REMU sequencer that borrows the shared 32-bit ALU one operation per cycle.
// Shift-add multiply (32 cycles) and restoring divide (32 compares plus one subtract per quotient 1-bit).
module alu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_less
);

  localparam logic [3:0]       ALU_ADD  = 4'd5;
  localparam logic [3:0]       ALU_SUB  = 4'd6;
  localparam logic [3:0]       ALU_SLTU = 4'd12;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_CMP, S_SUB, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   acc_reg, mc_reg, mp_reg;
  logic [XLEN-1:0]   q_reg, rem_reg, div_reg;
  logic [XLEN-1:0]   shifted;
  logic              ovf;
  logic              last_iter;
  logic              is_div_req;
  logic              need_sub;

  assign shifted    = {rem_reg[XLEN-2:0], q_reg[XLEN-1]};
  assign ovf        = rem_reg[XLEN-1];
  assign last_iter  = (cnt_reg == CNT_LAST);
  assign is_div_req = (req_op == 2'd1) || (req_op == 2'd2);
  // A set bit shifted out of rem means the partial remainder exceeds 32 bits, so it is >= divisor.
  assign need_sub   = ovf || !alu_less;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    busy       = 1'b0;
    alu_op     = 4'd0;
    alu_x      = '0;
    alu_y      = '0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = is_div_req ? S_CMP : S_MUL;
        end
      end
      S_MUL: begin
        busy   = 1'b1;
        alu_op = ALU_ADD;
        alu_x  = acc_reg;
        alu_y  = mp_reg[0] ? mc_reg : '0;
        if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_CMP: begin
        busy   = 1'b1;
        alu_op = ALU_SLTU;
        alu_x  = shifted;
        alu_y  = div_reg;
        if (need_sub) begin
          state_next = S_SUB;
        end else if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_SUB: begin
        busy       = 1'b1;
        alu_op     = ALU_SUB;
        alu_x      = rem_reg;
        alu_y      = div_reg;
        state_next = last_iter ? S_DONE : S_CMP;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        case (op_reg)
          2'd1:    resp_data = q_reg;
          2'd2:    resp_data = rem_reg;
          default: resp_data = acc_reg;
        endcase
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= '0;
      cnt_reg <= '0;
      acc_reg <= '0;
      mc_reg  <= '0;
      mp_reg  <= '0;
      q_reg   <= '0;
      rem_reg <= '0;
      div_reg <= '0;
    end else if (!flush) begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            op_reg  <= req_op;
            cnt_reg <= '0;
            if (is_div_req) begin
              q_reg   <= req_a;
              rem_reg <= '0;
              div_reg <= req_b;
            end else begin
              acc_reg <= '0;
              mc_reg  <= req_a;
              mp_reg  <= req_b;
            end
          end
        end
        S_MUL: begin
          acc_reg <= alu_result;
          mc_reg  <= {mc_reg[XLEN-2:0], 1'b0};
          mp_reg  <= {1'b0, mp_reg[XLEN-1:1]};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_CMP: begin
          rem_reg <= shifted;
          q_reg   <= {q_reg[XLEN-2:0], 1'b0};
          // The iteration only completes here when no subtract follows.
          if (!need_sub) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_SUB: begin
          rem_reg  <= alu_result;
          q_reg[0] <= 1'b1;
          cnt_reg  <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU (ADD/SUB/SLTU) wired to the sequencer.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] alu_result;
  logic        alu_less;

  int n_checks = 0;
  int n_pass   = 0;

  alu_muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .alu_less   (alu_less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'd5:    alu_result = alu_x + alu_y;
      4'd6:    alu_result = alu_x - alu_y;
      4'd12:   alu_result = {31'd0, alu_x < alu_y};
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_less = (alu_x < alu_y);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%08h", tag, got);
    end else begin
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request, wait for the response, optionally hold backpressure, then release.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input int exp_busy, input int hold);
    int cyc;
    int n_busy;
    int n_sub;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = 32'hDEADBEEF;
    req_b     = 32'h12345678;
    cyc    = 0;
    n_busy = 0;
    n_sub  = 0;
    while (!resp_valid && cyc < 200) begin
      if (busy) n_busy++;
      if (alu_op == 4'd6) n_sub++;
      cyc++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      check_eq({tag, " timeout"}, {31'd0, resp_valid}, 32'd1);
      return;
    end
    check_eq({tag, " data"}, resp_data, exp_data);
    check_eq({tag, " busy_cycles"}, n_busy, exp_busy);
    if (op == 2'd1 || op == 2'd2) begin
      check_eq({tag, " sub_cycles"}, n_sub, exp_busy - 32);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, " hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check_eq({tag, " hold_data"}, resp_data, exp_data);
      check_eq({tag, " hold_ready"}, {31'd0, req_ready}, 32'd0);
      check_eq({tag, " hold_aluop"}, {28'd0, alu_op}, 32'd0);
    end
    // A request presented alongside the release must not be taken in that cycle.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_op     = 2'd0;
    req_a      = 32'd3;
    req_b      = 32'd3;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check_eq({tag, " idle_after"}, {29'd0, req_ready, resp_valid, busy}, 32'b100);
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset valid_busy", {30'd0, resp_valid, busy}, 32'd0);
    check_eq("reset data", resp_data, 32'd0);
    check_eq("reset aluop", {28'd0, alu_op}, 32'd0);
    check_eq("reset alux_y", alu_x | alu_y, 32'd0);
    rst_n = 1'b1;

    run_op("mul 7x6", 2'd0, 32'd7, 32'd6, 32'h0000002A, 32, 10);
    run_op("mul ffx ff", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 0);
    run_op("mul op3 5x9", 2'd3, 32'd5, 32'd9, 32'd45, 32, 0);
    run_op("divu 100/7", 2'd1, 32'd100, 32'd7, 32'd14, 35, 0);
    run_op("remu 100/7", 2'd2, 32'd100, 32'd7, 32'd2, 35, 0);
    run_op("divu ovf", 2'd1, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33, 0);
    run_op("remu ovf", 2'd2, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, 0);
    run_op("divu 5/0", 2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 64, 0);
    run_op("remu 5/0", 2'd2, 32'd5, 32'd0, 32'd5, 64, 0);

    // Flush part-way through a divide.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush idle", {29'd0, req_ready, busy, resp_valid}, 32'b100);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    check_eq("flush no_resp", seen, 32'd0);

    // Flush in idle wins over a pending request.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd0;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check_eq("flush idle_noaccept", {30'd0, req_ready, busy}, 32'b10);
    run_op("mul 3x3", 2'd0, 32'd3, 32'd3, 32'd9, 32, 0);

    // Asynchronous reset between clock edges mid-multiply.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 32'd7;
    req_b     = 32'd6;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("arst busy_before", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst ready_busy", {30'd0, req_ready, busy}, 32'b10);
    check_eq("arst aluop", {28'd0, alu_op}, 32'd0);
    check_eq("arst alux_y", alu_x | alu_y, 32'd0);
    check_eq("arst resp", {31'd0, resp_valid} | resp_data, 32'd0);
    #1 rst_n = 1'b1;
    run_op("mul recover", 2'd0, 32'd7, 32'd6, 32'h0000002A, 32, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
